// File: rtl/layer5_argmax_if.sv
// Bundles the layer5_argmax logit stream and result bus.
// The slave modport is the argmax block and the master modport is its environment.
interface layer5_argmax_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic [3:0]            digit;
    logic [DATA_WIDTH-1:0] max_score;
    logic [3:0]            runner_up;
    logic [DATA_WIDTH-1:0] margin;
    logic [15:0]           frame_cnt;
    logic                  busy;
    logic                  timeout_err;

    modport master (
        output valid_in, in_data,
        input  out_valid, digit, max_score, runner_up, margin, frame_cnt, busy, timeout_err
    );

    modport slave (
        input  valid_in, in_data,
        output out_valid, digit, max_score, runner_up, margin, frame_cnt, busy, timeout_err
    );
endinterface

// File: rtl/layer5_argmax.sv
// Streaming argmax over one frame of NUM_CLASSES signed logits, tracking best and runner-up.
// Optional macro ARGMAX_TIMEOUT_EN adds an idle-gap abort of partial frames.
module layer5_argmax #(
    parameter int NUM_CLASSES    = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    layer5_argmax_if.slave    bus
);
    typedef enum logic {S_IDLE, S_RECV} state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

    state_t                        state_reg, state_next;
    logic [3:0]                    elem_idx_reg, elem_idx_next;
    logic signed [DATA_WIDTH-1:0]  best_reg, best_next;
    logic [3:0]                    best_idx_reg, best_idx_next;
    logic signed [DATA_WIDTH-1:0]  second_reg, second_next;
    logic [3:0]                    second_idx_reg, second_idx_next;
    logic                          second_valid_reg, second_valid_next;
    logic [3:0]                    digit_reg, digit_next;
    logic [DATA_WIDTH-1:0]         max_score_reg, max_score_next;
    logic [3:0]                    runner_up_reg, runner_up_next;
    logic [DATA_WIDTH-1:0]         margin_reg, margin_next;
    logic                          out_valid_reg, out_valid_next;
    logic [15:0]                   frame_cnt_reg, frame_cnt_next;
    logic signed [DATA_WIDTH-1:0]  x;

    assign x = bus.in_data;

`ifdef ARGMAX_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic             timeout_err_reg, timeout_err_next;
`endif

    always_comb begin
        state_next        = state_reg;
        elem_idx_next     = elem_idx_reg;
        best_next         = best_reg;
        best_idx_next     = best_idx_reg;
        second_next       = second_reg;
        second_idx_next   = second_idx_reg;
        second_valid_next = second_valid_reg;
        digit_next        = digit_reg;
        max_score_next    = max_score_reg;
        runner_up_next    = runner_up_reg;
        margin_next       = margin_reg;
        out_valid_next    = 1'b0;
        frame_cnt_next    = frame_cnt_reg;
`ifdef ARGMAX_TIMEOUT_EN
        gap_cnt_next      = '0;
        timeout_err_next  = 1'b0;
`endif
        if (bus.valid_in) begin
            if (elem_idx_reg == 4'd0) begin
                best_next         = x;
                best_idx_next     = 4'd0;
                second_valid_next = 1'b0;
            end else if (x > best_reg) begin
                // Strict compare keeps the earliest index on ties.
                second_next       = best_reg;
                second_idx_next   = best_idx_reg;
                second_valid_next = 1'b1;
                best_next         = x;
                best_idx_next     = elem_idx_reg;
            end else if (!second_valid_reg || x > second_reg) begin
                second_next       = x;
                second_idx_next   = elem_idx_reg;
                second_valid_next = 1'b1;
            end

            if (elem_idx_reg == LAST_IDX) begin
                digit_next     = best_idx_next;
                max_score_next = best_next;
                runner_up_next = second_idx_next;
                // best >= second, so the wrapped low bits equal the exact difference.
                margin_next    = best_next - second_next;
                out_valid_next = 1'b1;
                frame_cnt_next = frame_cnt_reg + 16'd1;
                elem_idx_next  = 4'd0;
                state_next     = S_IDLE;
            end else begin
                elem_idx_next  = elem_idx_reg + 4'd1;
                state_next     = S_RECV;
            end
        end
`ifdef ARGMAX_TIMEOUT_EN
        else if (state_reg == S_RECV) begin
            if (gap_cnt_reg == GAP_W'(TIMEOUT_CYCLES - 1)) begin
                state_next       = S_IDLE;
                elem_idx_next    = 4'd0;
                timeout_err_next = 1'b1;
            end else begin
                gap_cnt_next     = gap_cnt_reg + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            elem_idx_reg     <= '0;
            best_reg         <= '0;
            best_idx_reg     <= '0;
            second_reg       <= '0;
            second_idx_reg   <= '0;
            second_valid_reg <= 1'b0;
            digit_reg        <= '0;
            max_score_reg    <= '0;
            runner_up_reg    <= '0;
            margin_reg       <= '0;
            out_valid_reg    <= 1'b0;
            frame_cnt_reg    <= '0;
`ifdef ARGMAX_TIMEOUT_EN
            gap_cnt_reg      <= '0;
            timeout_err_reg  <= 1'b0;
`endif
        end else begin
            state_reg        <= state_next;
            elem_idx_reg     <= elem_idx_next;
            best_reg         <= best_next;
            best_idx_reg     <= best_idx_next;
            second_reg       <= second_next;
            second_idx_reg   <= second_idx_next;
            second_valid_reg <= second_valid_next;
            digit_reg        <= digit_next;
            max_score_reg    <= max_score_next;
            runner_up_reg    <= runner_up_next;
            margin_reg       <= margin_next;
            out_valid_reg    <= out_valid_next;
            frame_cnt_reg    <= frame_cnt_next;
`ifdef ARGMAX_TIMEOUT_EN
            gap_cnt_reg      <= gap_cnt_next;
            timeout_err_reg  <= timeout_err_next;
`endif
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.digit     = digit_reg;
    assign bus.max_score = max_score_reg;
    assign bus.runner_up = runner_up_reg;
    assign bus.margin    = margin_reg;
    assign bus.frame_cnt = frame_cnt_reg;
    assign bus.busy      = (state_reg == S_RECV);
`ifdef ARGMAX_TIMEOUT_EN
    assign bus.timeout_err = timeout_err_reg;
`else
    assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_layer5_argmax.sv
// Randomized scoreboard bench for layer5_argmax against a whole-frame argmax reference.
module tb_layer5_argmax;
    localparam int N  = 10;
    localparam int DW = 32;
    localparam int TO = 64;

    typedef struct {
        logic [3:0]  d;
        logic [31:0] mx;
        logic [3:0]  ru;
        logic [31:0] mg;
        logic [15:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   to_seen = 0;
    int   exp_to = 0;
    logic [15:0] frames_model = 16'd0;
    logic signed [31:0] cur [N];
    exp_t exp_q [$];
    int   ov_cyc [$];

    layer5_argmax_if #(.DATA_WIDTH(DW)) bus ();

    layer5_argmax #(.NUM_CLASSES(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
        end
    endtask

    // Reference: global maximum (lowest index on ties) and best of the remaining elements.
    function automatic exp_t model();
        exp_t e;
        int bi = 0;
        int ri;
        longint diff;
        for (int k = 1; k < N; k++) if (cur[k] > cur[bi]) bi = k;
        ri = (bi == 0) ? 1 : 0;
        for (int k = 0; k < N; k++) if (k != bi && cur[k] > cur[ri]) ri = k;
        diff = longint'(cur[bi]) - longint'(cur[ri]);
        e.d  = 4'(bi);
        e.mx = cur[bi];
        e.ru = 4'(ri);
        e.mg = diff[31:0];
        e.fc = 16'd0;
        return e;
    endfunction

    task automatic send_range(input int lo, input int hi, input int maxgap);
        exp_t e;
        for (int k = lo; k <= hi; k++) begin
            if (k != lo && maxgap > 0) begin
                repeat ($urandom_range(maxgap, 1)) begin
                    @(posedge clk); #1 bus.valid_in = 1'b0;
                end
            end
            @(posedge clk); #1;
            bus.valid_in = 1'b1;
            bus.in_data  = cur[k];
            if (k == N - 1) begin
                frames_model = frames_model + 16'd1;
                e = model();
                e.fc = frames_model;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1 bus.valid_in = 1'b0;
        end
    endtask

    task automatic drain();
        int i = 0;
        while (exp_q.size() > 0 && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (exp_q.size() > 0) begin
            total++; bad++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        chk({tag, "_out_valid"},   64'(bus.out_valid),   64'd0);
        chk({tag, "_digit"},       64'(bus.digit),       64'd0);
        chk({tag, "_max_score"},   64'(bus.max_score),   64'd0);
        chk({tag, "_runner_up"},   64'(bus.runner_up),   64'd0);
        chk({tag, "_margin"},      64'(bus.margin),      64'd0);
        chk({tag, "_frame_cnt"},   64'(bus.frame_cnt),   64'd0);
        chk({tag, "_busy"},        64'(bus.busy),        64'd0);
        chk({tag, "_timeout_err"}, 64'(bus.timeout_err), 64'd0);
    endtask

    task automatic rand_frame();
        for (int k = 0; k < N; k++)
            cur[k] = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
    endtask

    // Monitor: pops the scoreboard whenever a result is presented.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.timeout_err) to_seen++;
            if (bus.out_valid) begin
                ov_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out_valid digit=%0d required=no_result", bus.digit);
                end else begin
                    e = exp_q.pop_front();
                    chk("digit",     64'(bus.digit),     64'(e.d));
                    chk("max_score", 64'(bus.max_score), 64'(e.mx));
                    chk("runner_up", 64'(bus.runner_up), 64'(e.ru));
                    chk("margin",    64'(bus.margin),    64'(e.mg));
                    chk("frame_cnt", 64'(bus.frame_cnt), 64'(e.fc));
                    $display("frame %0d: digit=%0d runner_up=%0d max=%0h margin=%0h",
                             e.fc, bus.digit, bus.runner_up, bus.max_score, bus.margin);
                end
            end
        end
    end

    initial begin
        int n0;
        rst          = 1'b1;
        bus.valid_in = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        check_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        cur = '{-5, 3, 0, -1, 2, 9, 1, 1000, 4, -7};
        send_range(0, N - 1, 0); idle(2); drain();

        for (int k = 0; k < N; k++) cur[k] = 0;
        cur[2] = 500; cur[5] = 500;
        send_range(0, N - 1, 0); idle(2); drain();

        for (int k = 0; k < N; k++) cur[k] = 32'h8000_0000;
        send_range(0, N - 1, 0); idle(2); drain();

        cur[0] = 32'h7FFF_FFFF;
        send_range(0, N - 1, 0); idle(2); drain();

        // Back-to-back pair: results must be exactly N cycles apart.
        n0 = ov_cyc.size();
        rand_frame(); send_range(0, N - 1, 0);
        rand_frame(); send_range(0, N - 1, 0);
        idle(2); drain();
        if (ov_cyc.size() >= n0 + 2)
            chk("pair_spacing", 64'(ov_cyc[n0 + 1] - ov_cyc[n0]), 64'(N));
        else begin
            total++; bad++;
            $display("FAIL pair_spacing results=%0d required=2", ov_cyc.size() - n0);
        end

        rand_frame(); send_range(0, N - 1, 5); idle(2); drain();

        // Partial frame followed by a long idle gap.
        rand_frame();
        send_range(0, 3, 0);
        idle(TO + 6);
        @(negedge clk);
`ifdef ARGMAX_TIMEOUT_EN
        exp_to = 1;
        chk("busy_after_timeout", 64'(bus.busy), 64'd0);
        rand_frame(); send_range(0, N - 1, 0);
`else
        chk("busy_while_stalled", 64'(bus.busy), 64'd1);
        send_range(4, N - 1, 0);
`endif
        idle(2); drain();

        // Reset in the middle of a frame.
        rand_frame();
        send_range(0, 5, 0);
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        frames_model = 16'd0;
        check_zero("midframe_rst");
        rand_frame(); send_range(0, N - 1, 0); idle(2); drain();

        for (int f = 0; f < 20; f++) begin
            rand_frame();
            send_range(0, N - 1, $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(3); drain();

        chk("timeout_pulses", 64'(to_seen), 64'(exp_to));
        chk("final_frame_cnt", 64'(bus.frame_cnt), 64'(frames_model));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/layer5_argmax.md
# layer5_argmax

Classification back end for the MNIST pipeline. It consumes the serial int32 logit stream produced by the FC2 layer, one logit per `valid_in` cycle in class order 0..NUM_CLASSES-1. It tracks the best and runner-up classes on the fly and emits a one-cycle result pulse with the predicted digit, its score, the runner-up index and the decision margin. It applies no back-pressure; a new frame may start in the cycle its predecessor's result is presented.

## Interface
- `NUM_CLASSES`, 10: logits per frame (2..16).
- `DATA_WIDTH`, 32: signed logit width.
- `TIMEOUT_CYCLES`, 64: idle gap that aborts a partial frame; used only with `ARGMAX_TIMEOUT_EN`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  logit strobe; wired to FC2 `out_valid`.
- `in_data`  in  DATA_WIDTH  signed logit; wired to FC2 `out_data`.
- `out_valid`  out  1  one-cycle result pulse.
- `digit`  out  4  index of maximum logit.
- `max_score`  out  DATA_WIDTH  maximum logit value (signed).
- `runner_up`  out  4  index of second-best logit.
- `margin`  out  DATA_WIDTH  unsigned `max_score - second_score`.
- `frame_cnt`  out  16  completed frames, wraps at 65535 to 0.
- `busy`  out  1  high while a frame is partially received.
- `timeout_err`  out  1  one-cycle abort pulse.

## Operation
- States: `S_IDLE` (elem_idx = 0), `S_RECV` (0 < elem_idx < NUM_CLASSES).
- On every `valid_in` cycle, sample `in_data` as element `elem_idx`, then increment `elem_idx`.
- Element 0: best = x, best_idx = 0; second marked invalid.
- Element k ≥ 1:
  - If x > best (strict, signed): second ← best, second_idx ← best_idx, best ← x, best_idx ← k.
  - Else if second is invalid or x > second: second ← x, second_idx ← k.
- Strict comparison means ties resolve to the lowest index.
- On the last element (k = NUM_CLASSES-1), the results are computed from the updated trackers, including that element. In the same edge:
  - Register `digit`, `max_score`, `runner_up` and `margin`.
  - Pulse `out_valid` and increment `frame_cnt`.
  - Set elem_idx to 0 and return to `S_IDLE`.
- `margin` = best − second, computed at DATA_WIDTH+1 bits. It is non-negative by construction and the low DATA_WIDTH bits are exact; 0xFFFFFFFF is the maximum value.
- Result outputs hold their values until the next `out_valid`. `out_valid` and `timeout_err` are single-cycle pulses.
- `busy` = (state == `S_RECV`).
- Reset at any time, including mid-frame: the partial frame is discarded and every output goes to 0 (`digit`, `runner_up`, `max_score`, `margin`, `frame_cnt`, `out_valid`, `busy`, `timeout_err`). Trackers and elem_idx also go to 0.

## Timing
- Latency: `out_valid` is high in the cycle immediately after the cycle in which the last logit's `valid_in` was high.
- Throughput: one logit per cycle. Gaps between logits are allowed and stall the frame indefinitely, except as limited by the timeout below.
- Back-to-back frames: a `valid_in` in the `out_valid` cycle is element 0 of the next frame.
- `busy` rises in the cycle after element 0 is accepted. It falls in the same cycle that `out_valid` rises.

## Configuration
- `ARGMAX_TIMEOUT_EN` defined:
  - A gap counter counts consecutive cycles with `busy` = 1 and `valid_in` = 0; it clears on any `valid_in`.
  - When it reaches TIMEOUT_CYCLES, the partial frame is discarded and the block returns to `S_IDLE`.
  - `timeout_err` pulses high for one cycle; `out_valid` does not fire and `frame_cnt` is unchanged.
  - If `valid_in` arrives in the expiry cycle, it is taken as element 0 of a new frame.
- `ARGMAX_TIMEOUT_EN` undefined:
  - No counter is built, and a partial frame waits forever.
  - `timeout_err` is tied to 0; the port remains present.

## Test plan
- Logits {−5,3,0,−1,2,9,1,1000,4,−7}, contiguous → one cycle after the last logit: `out_valid` = 1, `digit` = 7, `max_score` = 1000, `runner_up` = 5, `margin` = 991, `frame_cnt` = 1.
- Ties: element 2 = 500 and element 5 = 500, others 0 → `digit` = 2, `runner_up` = 5, `margin` = 0.
- All ten logits = −2^31 → `digit` = 0, `runner_up` = 1, `margin` = 0, `max_score` = 0x80000000.
- Element 0 = 0x7FFFFFFF, rest = 0x80000000 → `digit` = 0, `margin` = 0xFFFFFFFF.
- Two frames back-to-back (20 contiguous `valid_in`), plus a frame with random 1–5 cycle gaps → each frame gives its `out_valid` exactly 10 cycles apart for the contiguous pair, correct `digit` for every frame, and `frame_cnt` = 3.
- Abort and reset cases:
  - With `ARGMAX_TIMEOUT_EN`: 4 logits then TIMEOUT_CYCLES idle → `timeout_err` pulse, no `out_valid`; a following full frame is correct.
  - `rst` asserted after 6 logits → all outputs 0 next cycle; the next frame is correct.
